// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and muldiv_unit.
// The master drives requests, flush and out_ready; the slave drives results.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             div_zero;

  modport master (
    output flush, in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, div_zero
  );

  modport slave (
    input  flush, in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, div_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative M-extension multiply/divide unit: shift-add multiply and
// restoring divide on magnitudes, STEP bits per busy cycle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);
  localparam int CYC = WIDTH / STEP;
  localparam int CW  = (CYC > 1) ? $clog2(CYC) : 1;
  localparam logic [CW-1:0] CNT_LD = CW'(CYC - 1);
  localparam logic [WIDTH-1:0] MIN_NEG =
    {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_it, full;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   res_q, res_d, fix;
  logic [WIDTH-1:0]   q_s, r_s;
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic               dz_q, dz_d;

  logic               accept, a_sgn, b_sgn;
  logic               bz, ovf, fast;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     diff, sm;

  // Request decode: sign flags, magnitudes, special cases
  always_comb begin
    accept = bus.in_valid && (state_q == IDLE)
             && !bus.flush;
    if (bus.op[2]) begin
      a_sgn = !bus.op[0] && bus.a[WIDTH-1];
      b_sgn = !bus.op[0] && bus.b[WIDTH-1];
    end else begin
      a_sgn = ((bus.op[1:0] == 2'd1)
               || (bus.op[1:0] == 2'd2))
              && bus.a[WIDTH-1];
      b_sgn = (bus.op[1:0] == 2'd1)
              && bus.b[WIDTH-1];
    end
    a_mag = a_sgn ? -bus.a : bus.a;
    b_mag = b_sgn ? -bus.b : bus.b;
    bz    = bus.op[2] && (bus.b == '0);
    ovf   = bus.op[2] && !bus.op[0]
            && (bus.a == MIN_NEG) && (bus.b == '1);
    fast  = bz || ovf;
  end

  always_comb begin
    acc_it = acc_q;
    diff   = '0;
    sm     = '0;
    for (int i = 0; i < STEP; i++) begin
      if (op_q[2]) begin
        diff = {acc_it[2*WIDTH-1:WIDTH],
                acc_it[WIDTH-1]}
               - {1'b0, opnd_q};
        if (!diff[WIDTH])
          acc_it = {diff[WIDTH-1:0],
                    acc_it[WIDTH-2:0], 1'b1};
        else
          acc_it = {acc_it[2*WIDTH-2:0], 1'b0};
      end else begin
        sm = {1'b0, acc_it[2*WIDTH-1:WIDTH]}
             + {1'b0, acc_it[0] ? opnd_q
                                : {WIDTH{1'b0}}};
        acc_it = {sm, acc_it[WIDTH-1:1]};
      end
    end
  end

  always_comb begin
    full = neg_q ? -acc_it : acc_it;
    q_s  = neg_q ? -acc_it[WIDTH-1:0]
                 : acc_it[WIDTH-1:0];
    r_s  = neg_q ? -acc_it[2*WIDTH-1:WIDTH]
                 : acc_it[2*WIDTH-1:WIDTH];
    fix  = '0;
    unique case (1'b1)
      (!op_q[2] && (op_q[1:0] == 2'd0)):
        fix = full[WIDTH-1:0];
      (!op_q[2] && (op_q[1:0] != 2'd0)):
        fix = full[2*WIDTH-1:WIDTH];
      (op_q[2] && !op_q[1]): fix = q_s;
      (op_q[2] && op_q[1]):  fix = r_s;
      default:               fix = '0;
    endcase
  end

  always_comb begin
    acc_d  = acc_q;
    opnd_d = opnd_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    neg_d  = neg_q;
    res_d  = res_q;
    dz_d   = dz_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = bus.op;
          cnt_d = CNT_LD;
          dz_d  = bz;
          neg_d = (bus.op[2] && bus.op[1])
                  ? a_sgn : (a_sgn ^ b_sgn);
          if (bz)
            res_d = bus.op[1] ? bus.a : '1;
          else if (ovf)
            res_d = bus.op[1] ? '0 : bus.a;
          // Divide keeps the dividend low; multiply keeps the multiplier low
          if (bus.op[2]) begin
            acc_d  = {{WIDTH{1'b0}}, a_mag};
            opnd_d = b_mag;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, b_mag};
            opnd_d = a_mag;
          end
        end
      end
      BUSY: begin
        acc_d = acc_it;
        if (cnt_q == '0) begin
          cnt_d = '0;
          res_d = fix;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:
          if (bus.in_valid)
            state_d = fast ? DONE : BUSY;
        BUSY:
          if (cnt_q == '0) state_d = DONE;
        DONE:
          if (bus.out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
  end

  assign bus.result   = res_q;
  assign bus.div_zero = dz_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      res_q  <= '0;
      dz_q   <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      neg_q  <= neg_d;
      res_q  <= res_d;
      dz_q   <= dz_d;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed + scoreboard bench for muldiv_unit with STEP=1 and STEP=4
// instances sharing one clock and reset.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) b1();
  muldiv_unit_if #(.WIDTH(32)) b4();

  muldiv_unit #(.WIDTH(32), .STEP(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1)
  );
  muldiv_unit #(.WIDTH(32), .STEP(4)) dut4 (
    .clk(clk), .rst(rst), .bus(b4)
  );

  typedef struct {
    logic [31:0] res;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic o_val(input bit s);
    return s ? b4.out_valid : b1.out_valid;
  endfunction
  function automatic logic o_rdy(input bit s);
    return s ? b4.in_ready : b1.in_ready;
  endfunction
  function automatic logic o_dz(input bit s);
    return s ? b4.div_zero : b1.div_zero;
  endfunction
  function automatic logic [31:0] o_res(input bit s);
    return s ? b4.result : b1.result;
  endfunction

  task automatic set_in(input bit s, input logic v,
                        input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b);
    if (s) begin
      b4.in_valid = v; b4.op = op; b4.a = a; b4.b = b;
    end else begin
      b1.in_valid = v; b1.op = op; b1.a = a; b1.b = b;
    end
  endtask

  task automatic set_ordy(input bit s, input logic v);
    if (s) b4.out_ready = v;
    else   b1.out_ready = v;
  endtask

  task automatic set_flush(input bit s, input logic v);
    if (s) b4.flush = v;
    else   b1.flush = v;
  endtask

  // Reference model from the ISA definition, using native arithmetic
  function automatic logic [32:0] model(
      input logic [2:0] op,
      input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb_, sp;
    logic [63:0] up;
    logic ov;
    sa  = {{32{a[31]}}, a};
    sb_ = {{32{b[31]}}, b};
    ov  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin
        up = {32'b0, a} * {32'b0, b};
        return {1'b0, up[31:0]};
      end
      3'd1: begin
        sp = sa * sb_;
        return {1'b0, sp[63:32]};
      end
      3'd2: begin
        sp = sa * $signed({32'b0, b});
        return {1'b0, sp[63:32]};
      end
      3'd3: begin
        up = {32'b0, a} * {32'b0, b};
        return {1'b0, up[63:32]};
      end
      3'd4: begin
        if (b == 0) return {1'b1, 32'hFFFF_FFFF};
        if (ov) return {1'b0, a};
        sp = sa / sb_;
        return {1'b0, sp[31:0]};
      end
      3'd5: begin
        if (b == 0) return {1'b1, 32'hFFFF_FFFF};
        return {1'b0, a / b};
      end
      3'd6: begin
        if (b == 0) return {1'b1, a};
        if (ov) return 33'd0;
        sp = sa % sb_;
        return {1'b0, sp[31:0]};
      end
      default: begin
        if (b == 0) return {1'b1, a};
        return {1'b0, a % b};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(1, 300));
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input bit s, input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] er,
                       input logic edz);
    exp_t e;
    logic fst;
    fst = op[2] && ((b == 0) || (!op[0]
          && (a == 32'h8000_0000)
          && (b == 32'hFFFF_FFFF)));
    e.res = er;
    e.dz  = edz;
    e.lat = fst ? 1 : (s ? 9 : 33);
    sb.push_back(e);
    set_in(s, 1'b1, op, a, b);
    @(posedge clk); #1;
    set_in(s, 1'b0, 3'($urandom), $urandom, $urandom);
  endtask

  task automatic await_res(input bit s, input string tag,
                           input int hold);
    exp_t e;
    int lat;
    lat = 1;
    while (!o_val(s) && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb.pop_front();
    chk({tag, " latency"}, 64'(lat), 64'(e.lat));
    chk({tag, " result"}, 64'(o_res(s)), 64'(e.res));
    chk({tag, " div_zero"}, 64'(o_dz(s)), 64'(e.dz));
    chk({tag, " in_ready busy"}, 64'(o_rdy(s)), 64'd0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk({tag, " hold valid"}, 64'(o_val(s)), 64'd1);
      chk({tag, " hold result"}, 64'(o_res(s)),
          64'(e.res));
      chk({tag, " hold in_ready"}, 64'(o_rdy(s)), 64'd0);
    end
  endtask

  task automatic consume(input bit s, input string tag);
    set_ordy(s, 1'b1);
    @(posedge clk); #1;
    set_ordy(s, 1'b0);
    chk({tag, " valid after take"}, 64'(o_val(s)), 64'd0);
    chk({tag, " ready after take"}, 64'(o_rdy(s)), 64'd1);
  endtask

  task automatic run(input bit s, input string tag,
                     input logic [2:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [31:0] er,
                     input logic edz);
    issue(s, op, a, b, er, edz);
    await_res(s, tag, 0);
    consume(s, tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] m;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    logic        seen;

    rst = 1'b1;
    set_in(0, 1'b0, 3'd0, '0, '0);
    set_in(1, 1'b0, 3'd0, '0, '0);
    set_ordy(0, 1'b0); set_ordy(1, 1'b0);
    set_flush(0, 1'b0); set_flush(1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset in_ready", 64'(o_rdy(0)), 64'd1);
    chk("reset out_valid", 64'(o_val(0)), 64'd0);
    chk("reset result", 64'(o_res(0)), 64'd0);
    chk("reset div_zero", 64'(o_dz(0)), 64'd0);
    chk("reset4 in_ready", 64'(o_rdy(1)), 64'd1);

    run(0, "mul", 3'd0, 32'd7, 32'hFFFF_FFFD,
        32'hFFFF_FFEB, 1'b0);
    run(0, "mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'hFFFF_FFFE, 1'b0);
    run(0, "mulh", 3'd1, 32'h8000_0000, 32'h8000_0000,
        32'h4000_0000, 1'b0);
    run(0, "mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2,
        32'hFFFF_FFFF, 1'b0);
    run(0, "div", 3'd4, 32'hFFFF_FFF9, 32'd2,
        32'hFFFF_FFFD, 1'b0);
    run(0, "rem", 3'd6, 32'hFFFF_FFF9, 32'd2,
        32'hFFFF_FFFF, 1'b0);
    run(0, "divu", 3'd5, 32'd100, 32'd7, 32'd14, 1'b0);
    run(0, "remu", 3'd7, 32'd100, 32'd7, 32'd2, 1'b0);
    run(0, "divu0", 3'd5, 32'h1234, 32'd0,
        32'hFFFF_FFFF, 1'b1);
    run(0, "rem0", 3'd6, 32'h1234, 32'd0,
        32'h1234, 1'b1);
    run(0, "divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF,
        32'h8000_0000, 1'b0);
    run(0, "removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF,
        32'd0, 1'b0);

    issue(0, 3'd0, 32'd1000, 32'd3000, 32'd3_000_000, 1'b0);
    await_res(0, "bp", 10);
    consume(0, "bp");

    issue(0, 3'd0, 32'd9, 32'd9, 32'd81, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    set_flush(0, 1'b1);
    @(posedge clk); #1;
    set_flush(0, 1'b0);
    void'(sb.pop_front());
    chk("flush in_ready", 64'(o_rdy(0)), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= o_val(0);
    end
    chk("flush no valid", 64'(seen), 64'd0);
    run(0, "mul after flush", 3'd0, 32'd12345, 32'd678,
        32'd8_369_910, 1'b0);

    issue(0, 3'd0, 32'd9, 32'd9, 32'd81, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sb.pop_front());
    chk("rst in_ready", 64'(o_rdy(0)), 64'd1);
    chk("rst out_valid", 64'(o_val(0)), 64'd0);
    chk("rst result", 64'(o_res(0)), 64'd0);
    chk("rst div_zero", 64'(o_dz(0)), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= o_val(0);
    end
    chk("rst no valid", 64'(seen), 64'd0);
    run(0, "mul after rst", 3'd0, 32'hFFFF_FFFF, 32'd5,
        32'hFFFF_FFFB, 1'b0);

    set_in(0, 1'b1, 3'd0, 32'd5, 32'd6);
    set_flush(0, 1'b1);
    @(posedge clk); #1;
    set_in(0, 1'b0, 3'd0, '0, '0);
    set_flush(0, 1'b0);
    chk("flush blocks req", 64'(o_rdy(0)), 64'd1);
    @(posedge clk); #1;
    chk("flush blocks valid", 64'(o_val(0)), 64'd0);

    issue(0, 3'd5, 32'd50, 32'd0, 32'hFFFF_FFFF, 1'b1);
    await_res(0, "done flush", 0);
    set_flush(0, 1'b1);
    @(posedge clk); #1;
    set_flush(0, 1'b0);
    chk("done flush valid", 64'(o_val(0)), 64'd0);
    chk("done flush ready", 64'(o_rdy(0)), 64'd1);

    run(1, "mul step4", 3'd0, 32'h1234_5678, 32'h9ABC_DEF0,
        32'h242D_2080, 1'b0);
    m = model(3'd1, 32'hDEAD_BEEF, 32'h1234_5678);
    run(1, "mulh step4", 3'd1, 32'hDEAD_BEEF, 32'h1234_5678,
        m[31:0], m[32]);
    run(1, "rem step4", 3'd6, 32'hFFFF_FF9C, 32'd7,
        32'hFFFF_FFFE, 1'b0);

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom);
      ra  = pick();
      rb  = pick();
      m   = model(rop, ra, rb);
      run(i[0], "random", rop, ra, rb, m[31:0], m[32]);
    end

    chk("scoreboard empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative, parametrised multiply/divide execution unit for the core's M-extension ops. It sits beside the single-cycle ALU in the execute stage. It accepts one operation through a valid/ready handshake and computes it over multiple cycles. It returns the result through a second valid/ready handshake, with fast paths for divide special cases and a flush for pipeline squash.

Parameters:
WIDTH, 32, operand and result width in bits; must be at least 2.
STEP, 1, bits processed per busy cycle; must divide WIDTH exactly. Busy phase lasts WIDTH/STEP cycles.

Ports:
clk  input  1  clock, rising-edge
rst  input  1  synchronous, active-high reset
flush  input  1  abort any in-flight op and drop any unconsumed result
in_valid  input  1  operation request
in_ready  output  1  unit can accept; high only in IDLE
op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
a  input  WIDTH  rs1 operand
b  input  WIDTH  rs2 operand
out_valid  output  1  result available; high only in DONE
out_ready  input  1  consumer takes result
result  output  WIDTH  result, stable while out_valid
div_zero  output  1  result came from divide/remainder by zero; qualified by out_valid

Behaviour:
- Reset: one clock (clk) for the whole block; reset rst is synchronous and active-high. On rst: state IDLE, out_valid=0, result=0, div_zero=0, counter=0, in_ready=1 in the cycle after the reset edge. Reset mid-operation discards the operation silently.
- States: IDLE, BUSY, DONE.
- IDLE -> BUSY: on an edge with in_valid & in_ready & !flush. At that edge, latch op, a and b (converted to magnitudes with sign flags as the op requires) and load counter = WIDTH/STEP - 1.
- IDLE -> DONE (fast path) for divide special cases, without entering BUSY:
  - b == 0: DIV/DIVU give all-ones; REM/REMU give a; div_zero=1.
  - DIV/REM with a == most-negative and b == all-ones: DIV gives a; REM gives 0; div_zero=0.
- BUSY: each cycle performs STEP shift-add (multiply) or STEP restoring-subtract (divide) iterations and decrements counter. On the cycle with counter==0, apply the sign fix-up and go to DONE. Normal latency: acceptance edge to the first out_valid cycle is WIDTH/STEP + 1 edges (33 for the defaults). Fast path: 1 edge.
- DONE: out_valid=1 and result held stable until an edge with out_ready. That edge returns to IDLE. No new op is accepted in the same cycle (no bypass).
- Arithmetic:
  - Full 2*WIDTH product.
  - MUL returns the low half.
  - MULH returns the high half of signed x signed.
  - MULHSU returns the high half of signed a x unsigned b.
  - MULHU returns the high half of unsigned x unsigned.
  - DIV/REM truncate toward zero; the remainder takes the sign of the dividend.
  - DIVU/REMU are unsigned.
  - div_zero=0 for all multiply ops.
- flush: takes priority over every other event. At an edge with flush=1 the unit goes to IDLE from any state and out_valid=0 next cycle. A request coinciding with flush is not accepted. A flush coinciding with an out_ready handshake consumes nothing further.
- in_ready depends only on state (no combinational path from out_ready).
- a, b and op may change freely after acceptance.

Test Plan:
- Multiply, WIDTH=32, STEP=1: MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF. Each has out_valid exactly 33 edges after acceptance.
- Signed divide: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14; REMU -> 2.
- Special cases: DIVU 0x1234 / 0 -> 0xFFFFFFFF with div_zero=1. REM 0x1234 / 0 -> 0x1234 with div_zero=1. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 with div_zero=0. REM of the same -> 0. All have out_valid 1 edge after acceptance.
- Backpressure: out_ready held low 10 cycles after out_valid -> result and out_valid stable, in_ready=0. Raising out_ready -> in_ready=1 next cycle.
- Flush and reset: flush at busy cycle 5 -> out_valid never asserts and in_ready=1 next cycle. rst at busy cycle 5 -> same, outputs at reset values. A back-to-back MUL after either gives the correct result.
- STEP=4, WIDTH=32: MUL 0x12345678 x 0x9ABCDEF0 -> low word 0x242D2080, out_valid 9 edges after acceptance.
